// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty fade sequencer.
package pwm_ctrl_pkg;

    localparam int DUTY_W = 4;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Counts PWM period wraps up to a terminal count; flags the wrap that reaches it.
module pwm_period_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_wrap,
    input  logic [W-1:0] i_tc,
    output logic         o_tc_hit
);

    logic [W-1:0] cnt_q;
    logic [W:0]   cnt_nx;

    // One bit wider so the compare holds even when i_tc is all ones.
    assign cnt_nx   = {1'b0, cnt_q} + (W+1)'(1);
    assign o_tc_hit = i_wrap && (cnt_nx >= {1'b0, i_tc});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_wrap && (cnt_q < i_tc)) begin
            cnt_q <= cnt_nx[W-1:0];
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty fade sequencer: ramps the PWM duty between latched limits, changing it
// only on PWM period wraps.
//
//   state   | meaning
//   IDLE    | waiting for i_start, o_w holds last value
//   UP      | first wrap loads min, then +1 per step count
//   HOLD_HI | holding at max for hold periods
//   DOWN    | -1 per step count until min
//   HOLD_LO | holding at min for hold periods, then end of cycle
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [3:0]        i_min,
    input  logic [3:0]        i_max,
    input  logic [STEP_W-1:0] i_step_periods,
    input  logic [STEP_W-1:0] i_hold_periods,
    input  logic              i_loop,
    input  logic              i_wrap,
    output logic [3:0]        o_w,
    output logic              o_busy,
    output logic              o_cycle_done,
    output logic [2:0]        o_state
);

    state_t state_q, state_d;
    logic [DUTY_W-1:0] w_q, w_d, min_q, max_q;
    logic [STEP_W-1:0] step_q, hold_q, tc;
    logic loop_q, first_q, first_d, stop_q, stop_d;
    logic busy_q, done_q, done_d;
    logic tmr_clr, tmr_hit, end_cyc, hold_zero;

    assign hold_zero = (hold_q == '0);
    assign tc = ((state_q == HOLD_HI) || (state_q == HOLD_LO)) ? hold_q : step_q;

    pwm_period_timer #(.W(STEP_W)) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (tmr_clr),
        .i_wrap   (i_wrap),
        .i_tc     (tc),
        .o_tc_hit (tmr_hit)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        first_d = first_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        tmr_clr = 1'b0;
        end_cyc = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_clr = 1'b1;
                if (i_start) begin
                    state_d = UP;
                    first_d = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            UP: begin
                if (i_stop) begin
                    stop_d  = 1'b1;
                    state_d = DOWN;
                    tmr_clr = 1'b1;
                end else if (first_q) begin
                    if (i_wrap) begin
                        w_d     = min_q;
                        first_d = 1'b0;
                        tmr_clr = 1'b1;
                        if (min_q == max_q)
                            state_d = hold_zero ? DOWN : HOLD_HI;
                    end
                end else if (tmr_hit) begin
                    tmr_clr = 1'b1;
                    if (w_q < max_q)
                        w_d = w_q + DUTY_W'(1);
                    if ((w_q >= max_q) || (w_q + DUTY_W'(1) == max_q))
                        state_d = hold_zero ? DOWN : HOLD_HI;
                end
            end
            HOLD_HI: begin
                if (i_stop) begin
                    stop_d  = 1'b1;
                    state_d = DOWN;
                    tmr_clr = 1'b1;
                end else if (tmr_hit) begin
                    state_d = DOWN;
                    tmr_clr = 1'b1;
                end
            end
            DOWN: begin
                if (i_stop)
                    stop_d = 1'b1;
                if (tmr_hit) begin
                    tmr_clr = 1'b1;
                    // Guard against entering DOWN already at (or below) min.
                    if (w_q > min_q)
                        w_d = w_q - DUTY_W'(1);
                    if ((w_q <= min_q) || (w_q - DUTY_W'(1) == min_q)) begin
                        if (hold_zero)
                            end_cyc = 1'b1;
                        else
                            state_d = HOLD_LO;
                    end
                end
            end
            HOLD_LO: begin
                if (i_stop)
                    stop_d = 1'b1;
                if (tmr_hit)
                    end_cyc = 1'b1;
            end
            default: begin
                state_d = IDLE;
                tmr_clr = 1'b1;
            end
        endcase

        if (end_cyc) begin
            done_d  = 1'b1;
            tmr_clr = 1'b1;
            first_d = 1'b0;
            if (loop_q && !stop_d) begin
                state_d = UP;
            end else begin
                state_d = IDLE;
                stop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            first_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            first_q <= first_d;
            stop_q  <= stop_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            min_q  <= '0;
            max_q  <= '0;
            step_q <= '0;
            hold_q <= '0;
            loop_q <= 1'b0;
        end else if ((state_q == IDLE) && i_start) begin
            min_q  <= i_min;
            max_q  <= (i_min > i_max) ? i_min : i_max;
            step_q <= (i_step_periods == '0) ? STEP_W'(1) : i_step_periods;
            hold_q <= i_hold_periods;
            loop_q <= i_loop;
        end
    end

    assign o_w          = w_q;
    assign o_busy       = busy_q;
    assign o_cycle_done = done_q;
    assign o_state      = state_q;

endmodule

// File: doc/pwm_fade_ctrl.md
# pwm_fade_ctrl

- Sequencer that drives the 4-bit duty input of the PWM generator.
- Ramps the duty up and down between programmable limits, with programmable step rate and hold times, in one-shot or looping "breathing" mode.
- Updates the duty only on PWM period boundaries, signalled by `i_wrap`, so every PWM period runs at one constant duty.
- Sits between register/control logic and the PWM generator.

## Interface

- `STEP_W`, default 16: width of the step and hold period counts.
- `i_clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  start pulse. Samples all configuration inputs.
- `i_stop`  in  1  stop request pulse.
- `i_min`  in  4  lower duty limit.
- `i_max`  in  4  upper duty limit.
- `i_step_periods`  in  STEP_W  PWM periods per duty step. 0 is treated as 1.
- `i_hold_periods`  in  STEP_W  extra periods held at each limit. 0 means no hold.
- `i_loop`  in  1  1 = repeat cycles until stopped; 0 = one-shot.
- `i_wrap`  in  1  high for the single cycle in which the PWM counter equals 4'hF.
- `o_w`  out  4  duty value, to the generator's duty input.
- `o_busy`  out  1  high in any state other than IDLE.
- `o_cycle_done`  out  1  one-cycle pulse at the end of each down ramp and its low hold.
- `o_state`  out  3  current FSM state, for debug.

## Operation

- **States:** IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- **Event rule:** all duty changes and counter increments occur only on cycles with `i_wrap` = 1. The period counter counts wraps.
- **Start:** `i_start` in IDLE latches the config and enters UP with a first-load flag set. `i_start` while busy is ignored.
- **Limit clamp:** if `i_min` > `i_max`, the latched max is set to `i_min` (flat ramp).
- **UP:**
  - First wrap: `o_w` ← min. If min == max, go to HOLD_HI.
  - Afterwards, each time the counter reaches the step count: counter clears and `o_w` increments.
  - If the new value equals max, go to HOLD_HI.
- **HOLD_HI:** after hold wraps, go to DOWN with the counter cleared. If hold == 0, skip HOLD_HI and go straight to DOWN.
- **DOWN:** on each step boundary `o_w` decrements. When it reaches min, go to HOLD_LO (skipped if hold == 0).
- **End of cycle (HOLD_LO end, or DOWN end when hold == 0):**
  - Pulse `o_cycle_done`.
  - If loop == 1 and no stop is pending: go to UP with no first load (`o_w` is already min).
  - Otherwise go to IDLE.
- **Stop:** `i_stop` while busy sets stop-pending.
  - In UP or HOLD_HI: jump to DOWN next cycle, counter cleared.
  - In DOWN or HOLD_LO: continue.
  - Ends in IDLE via the normal end-of-cycle path.
  - `i_stop` in IDLE is ignored.
  - Simultaneous `i_start` and `i_stop` in IDLE: start accepted, stop ignored.
- **IDLE:** `o_w` holds its last value.
- **Widths:** duty arithmetic is 4-bit unsigned and never wraps, because it is bounded by min/max. The step counter is STEP_W bits and saturates at the terminal count.

## Timing

- **Reset values:** `o_w` = 0, `o_busy` = 0, `o_cycle_done` = 0, `o_state` = IDLE, counters and flags 0. Reset applies immediately when `i_rst_n` falls, including mid-ramp.
- All outputs are registered.
- `o_busy` rises the cycle after `i_start` and falls in the same cycle `o_cycle_done` pulses for the final cycle.
- `o_w` changes the clock after an `i_wrap` cycle. The generator therefore sees the new duty from counter value 0 of the next period.
- Each intermediate level lasts step periods.
- Max lasts hold + step periods. Min at the end of the cycle lasts hold periods.

## Structure

- **Package `pwm_ctrl_pkg`:** contains
  - the state enum typedef,
  - `DUTY_W` = 4,
  - `DUTY_MAX` = 4'hF.
- **Sub-module `pwm_period_timer`:** counts `i_wrap` events up to a terminal count. Provides a synchronous clear and a terminal-count pulse. Used for both step and hold counting.
- **Top-level integration:** `i_wrap` is driven from the generator's test duty-count output, compared against 4'hF.

## Test plan

1. **Reset:**
   - Stimulus: assert `i_rst_n` low between clock edges, mid-ramp at `o_w` = 4.
   - Response: `o_w` = 0, busy = 0, state IDLE with no clock edge. No activity after release until `i_start`.
2. **One-shot, hold 2:**
   - Stimulus: min = 2, max = 5, step = 1, hold = 2, loop = 0, wrap every 16 cycles.
   - Response: `o_w` after wraps 1–11 = 2, 3, 4, 5, 5, 5, 4, 3, 2, 2, 2. `o_cycle_done` pulses the cycle after wrap 11, busy drops with it, `o_w` holds 2.
3. **Step count and zero hold:**
   - Stimulus: step = 3, hold = 0.
   - Response: `o_w` changes only every third wrap, with no hold periods.
   - Repeat with step = 0: behaves exactly as step = 1.
4. **Loop with stop:**
   - Stimulus: loop = 1, min = 0, max = 8, step = 1. Pulse `i_stop` during UP at `o_w` = 4.
   - Response: state DOWN next cycle, `o_w` = 3, 2, 1, 0 on subsequent wraps, then one `o_cycle_done` and IDLE.
5. **Ignored start and inverted limits:**
   - Stimulus: `i_start` pulsed while busy.
   - Response: config unchanged.
   - Stimulus: min = 7, max = 3, hold = 1.
   - Response: `o_w` = 7 throughout, done after the hold, IDLE.
6. **Start and stop together from IDLE:**
   - Stimulus: `i_start` and `i_stop` in the same cycle while IDLE.
   - Response: start accepted, full cycle runs.
